// File: rtl/stack_driver_if.sv
// Host-side command/response bundle for stack_driver.
// The host (master) presents commands and the driver (slave) returns completions.
interface stack_driver_if;
  logic       cmd_valid;
  logic       cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/stack_driver.sv
// Sequences push/pop commands onto a hardware stack via a done-flag handshake and keeps a shadow depth.
// Optional per-phase handshake timeout enabled by defining STACK_DRIVER_TIMEOUT_EN.
module stack_driver #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  stack_driver_if.slave        host,
  output logic                 stk_push,
  output logic                 stk_pop,
  output logic [7:0]           stk_wdata,
  input  logic [7:0]           stk_rdata,
  input  logic                 stk_done,
  output logic [4:0]           depth
);

  localparam int unsigned DW = 5;

  if (DEPTH < 1 || DEPTH > 31 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
    $error("stack_driver: DEPTH must be 1..31 and TIMEOUT 1..255");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  state_t         state, state_n;
  logic           op, op_n;
  logic           push_n, pop_n;
  logic [7:0]     wdata_n;
  logic           rsp_valid, rsp_valid_n;
  logic           rsp_err, rsp_err_n;
  logic [7:0]     rsp_data, rsp_data_n;
  logic [DW-1:0]  depth_n;
  logic           cmd_ready_c;
  logic           accept;
  logic           reject;

`ifdef STACK_DRIVER_TIMEOUT_EN
  logic [7:0]     cnt, cnt_n;
  logic           expired;
  assign expired = (cnt == 8'(TIMEOUT - 1));
`endif

  assign cmd_ready_c    = (state == IDLE) && stk_done && !rst;
  assign accept         = host.cmd_valid && cmd_ready_c;
  assign reject         = host.cmd_op ? (depth == '0) : (depth == DW'(DEPTH));
  assign host.cmd_ready = cmd_ready_c;
  assign host.rsp_valid = rsp_valid;
  assign host.rsp_data  = rsp_data;
  assign host.rsp_err   = rsp_err;

  // Next-state and next-output logic; strobes and rsp_valid default low.
  always_comb begin
    state_n     = state;
    op_n        = op;
    push_n      = 1'b0;
    pop_n       = 1'b0;
    wdata_n     = stk_wdata;
    rsp_valid_n = 1'b0;
    rsp_err_n   = rsp_err;
    rsp_data_n  = rsp_data;
    depth_n     = depth;
`ifdef STACK_DRIVER_TIMEOUT_EN
    cnt_n       = cnt;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          op_n    = host.cmd_op;
          wdata_n = host.cmd_data;
`ifdef STACK_DRIVER_TIMEOUT_EN
          cnt_n   = 8'd0;
`endif
          if (reject) begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
            rsp_data_n  = 8'd0;
          end else begin
            state_n = ISSUE;
            push_n  = !host.cmd_op;
            pop_n   = host.cmd_op;
          end
        end
      end
      ISSUE: state_n = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!stk_done) begin
          state_n = WAIT_DONE;
`ifdef STACK_DRIVER_TIMEOUT_EN
          cnt_n   = 8'd0;
        end else if (expired) begin
          state_n     = RESP;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          rsp_data_n  = 8'd0;
        end else begin
          cnt_n = cnt + 8'd1;
`endif
        end
      end
      WAIT_DONE: begin
        if (stk_done) begin
          state_n     = RESP;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b0;
          rsp_data_n  = op ? stk_rdata : 8'd0;
          depth_n     = op ? depth - DW'(1) : depth + DW'(1);
`ifdef STACK_DRIVER_TIMEOUT_EN
        end else if (expired) begin
          state_n     = RESP;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          rsp_data_n  = 8'd0;
        end else begin
          cnt_n = cnt + 8'd1;
`endif
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; reset wins from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op        <= 1'b0;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      stk_wdata <= 8'd0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= 8'd0;
      depth     <= '0;
`ifdef STACK_DRIVER_TIMEOUT_EN
      cnt       <= 8'd0;
`endif
    end else begin
      state     <= state_n;
      op        <= op_n;
      stk_push  <= push_n;
      stk_pop   <= pop_n;
      stk_wdata <= wdata_n;
      rsp_valid <= rsp_valid_n;
      rsp_err   <= rsp_err_n;
      rsp_data  <= rsp_data_n;
      depth     <= depth_n;
`ifdef STACK_DRIVER_TIMEOUT_EN
      cnt       <= cnt_n;
`endif
    end
  end

endmodule
